gen_hs_cdc_rx: RTL and testbench

GEN_HS_CDC_RX -- requirements
Module: gen_hs_cdc_rx

---
 rtl/gen_hs_cdc_rx.sv | 106 ++++++++++
 tb/tb_gen_hs_cdc_rx.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/gen_hs_cdc_rx.sv
// Receive side of a 4-phase req/ack clock-domain crossing: synchronizes req_i,
// captures the payload once per request and hands it to a valid/ready consumer.
module gen_hs_cdc_rx #(
    parameter int unsigned DP = 2,
    parameter int unsigned DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req_i,
    input  logic [DW-1:0] data_i,
    output logic          ack_o,
    output logic [DW-1:0] dout_o,
    output logic          vld_o,
    input  logic          rdy_i,
    output logic          err_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        ACK  = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic [DP-1:0] sync_q;
    logic          req_s;
    logic          ack_q, ack_d;
    logic          vld_q, vld_d;
    logic          err_q, err_d;
    logic [DW-1:0] dout_q, dout_d;

    // Request synchronizer; the only place req_i is sampled.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[DP-2:0], req_i};
        end
    end

    assign req_s = sync_q[DP-1];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ack_q   <= 1'b0;
            vld_q   <= 1'b0;
            err_q   <= 1'b0;
            dout_q  <= '0;
        end else begin
            state_q <= state_d;
            ack_q   <= ack_d;
            vld_q   <= vld_d;
            err_q   <= err_d;
            dout_q  <= dout_d;
        end
    end

    // data_i is only looked at on the IDLE->HOLD edge, when the source holds it stable.
    always_comb begin
        state_d = state_q;
        ack_d   = ack_q;
        vld_d   = vld_q;
        err_d   = err_q;
        dout_d  = dout_q;
        case (state_q)
            IDLE: begin
                vld_d = 1'b0;
                ack_d = 1'b0;
                if (req_s) begin
                    dout_d  = data_i;
                    vld_d   = 1'b1;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                // Source withdrew its request before being acknowledged.
                if (!req_s) begin
                    err_d = 1'b1;
                end
                if (rdy_i) begin
                    vld_d   = 1'b0;
                    ack_d   = 1'b1;
                    state_d = ACK;
                end
            end
            ACK: begin
                if (!req_s) begin
                    ack_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                ack_d   = 1'b0;
                vld_d   = 1'b0;
            end
        endcase
    end

    assign ack_o  = ack_q;
    assign vld_o  = vld_q;
    assign err_o  = err_q;
    assign dout_o = dout_q;

endmodule

// File: tb/tb_gen_hs_cdc_rx.sv
// Bench for gen_hs_cdc_rx: DP=2 and DP=3 instances share stimulus; each is
// compared every cycle against a delay-line/transaction model, plus directed checks.
module tb_gen_hs_cdc_rx;

    localparam int unsigned DW = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req;
    logic          rdy;
    logic [DW-1:0] data;
    logic          ack0, vld0, err0, ack1, vld1, err1;
    logic [DW-1:0] dout0, dout1;

    always #5 clk = ~clk;

    gen_hs_cdc_rx #(.DP(2), .DW(DW)) u_dp2 (
        .clk(clk), .rst_n(rst_n), .req_i(req), .data_i(data), .ack_o(ack0),
        .dout_o(dout0), .vld_o(vld0), .rdy_i(rdy), .err_o(err0)
    );

    gen_hs_cdc_rx #(.DP(3), .DW(DW)) u_dp3 (
        .clk(clk), .rst_n(rst_n), .req_i(req), .data_i(data), .ack_o(ack1),
        .dout_o(dout1), .vld_o(vld1), .rdy_i(rdy), .err_o(err1)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Reference model: req as seen by the FSM is req_i sampled DP edges earlier.
    int unsigned   dp_of [2] = '{2, 3};
    bit            hist[$];
    bit            m_full[2], m_ack[2], m_err[2];
    logic [DW-1:0] m_dout[2];
    bit            m_live = 1'b0;
    logic [DW-1:0] got0[$];
    logic [DW-1:0] sent[$];

    function automatic void model_edge();
        bit rs;
        if (!rst_n) begin
            for (int k = 0; k < 2; k++) begin
                m_full[k] = 1'b0; m_ack[k] = 1'b0; m_err[k] = 1'b0; m_dout[k] = '0;
            end
            hist.delete();
            repeat (4) hist.push_back(1'b0);
            m_live = 1'b1;
        end else if (m_live) begin
            for (int k = 0; k < 2; k++) begin
                rs = hist[dp_of[k]-1];
                if (m_full[k]) begin
                    if (!rs) m_err[k] = 1'b1;
                    if (rdy) begin m_full[k] = 1'b0; m_ack[k] = 1'b1; end
                end else if (m_ack[k]) begin
                    if (!rs) m_ack[k] = 1'b0;
                end else if (rs) begin
                    m_full[k] = 1'b1;
                    m_dout[k] = data;
                end
            end
            hist.push_front(req);
            if (hist.size() > 4) void'(hist.pop_back());
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        if (rst_n === 1'b1 && vld0 === 1'b1 && rdy === 1'b1) got0.push_back(dout0);
        model_edge();
        #1;
        if (m_live) begin
            chk("m_vld0", 64'(vld0), 64'(m_full[0]));
            chk("m_ack0", 64'(ack0), 64'(m_ack[0]));
            chk("m_err0", 64'(err0), 64'(m_err[0]));
            chk("m_dout0", 64'(dout0), 64'(m_dout[0]));
            chk("m_vld1", 64'(vld1), 64'(m_full[1]));
            chk("m_ack1", 64'(ack1), 64'(m_ack[1]));
            chk("m_err1", 64'(err1), 64'(m_err[1]));
            chk("m_dout1", 64'(dout1), 64'(m_dout[1]));
        end
    endtask

    task automatic rtick();
        rdy = 1'($urandom_range(0, 1));
        tick();
    endtask

    task automatic do_reset();
        rst_n = 1'b0; req = 1'b0; rdy = 1'b0; data = '0;
        tick();
        rst_n = 1'b1;
        repeat (2) tick();
    endtask

    task automatic wait_ack(input logic lvl, input bit rand_rdy);
        int n = 0;
        while (ack0 !== lvl && n < 200) begin
            if (rand_rdy) rtick(); else tick();
            n++;
        end
        chk("ack_wait", 64'(ack0), 64'(lvl));
    endtask

    task automatic wait_vld();
        int n = 0;
        while (vld0 !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk("vld_wait", 64'(vld0), 64'd1);
    endtask

    logic          v0[8], a0[8], v1[8], a1[8];
    logic [DW-1:0] d0[8];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; req = 1'b0; rdy = 1'b0; data = '0;

        // Reset state and single transfer latency / one-cycle valid
        do_reset();
        chk("rst_vld0", 64'(vld0), 64'd0);
        chk("rst_ack0", 64'(ack0), 64'd0);
        chk("rst_dout0", 64'(dout0), 64'd0);
        rdy = 1'b1; data = 32'hDEADBEEF; req = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            v0[i] = vld0; a0[i] = ack0; v1[i] = vld1; d0[i] = dout0;
        end
        chk("t1_vld_early", 64'(v0[1]), 64'd0);
        chk("t1_vld_dp2", 64'(v0[2]), 64'd1);
        chk("t1_vld_1cyc", 64'(v0[3]), 64'd0);
        chk("t1_ack_pre", 64'(a0[2]), 64'd0);
        chk("t1_ack_rise", 64'(a0[3]), 64'd1);
        chk("t1_dout", 64'(d0[2]), 64'hDEADBEEF);
        chk("t1_vld_dp3_early", 64'(v1[2]), 64'd0);
        chk("t1_vld_dp3", 64'(v1[3]), 64'd1);
        chk("t1_vld_dp3_1cyc", 64'(v1[4]), 64'd0);

        // Acknowledge release latency
        req = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            a0[i] = ack0; a1[i] = ack1;
        end
        chk("t1_ack_hold", 64'(a0[1]), 64'd1);
        chk("t1_ack_rel", 64'(a0[2]), 64'd0);
        chk("t1_ack_hold_dp3", 64'(a1[2]), 64'd1);
        chk("t1_ack_rel_dp3", 64'(a1[3]), 64'd0);

        // Consumer stalls for 5 cycles
        rdy = 1'b0; data = 32'h0BADF00D; req = 1'b1;
        wait_vld();
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t2_vld_stall", 64'(vld0), 64'd1);
            chk("t2_dout_stall", 64'(dout0), 64'h0BADF00D);
            chk("t2_ack_stall", 64'(ack0), 64'd0);
        end
        rdy = 1'b1;
        tick();
        chk("t2_vld_clr", 64'(vld0), 64'd0);
        chk("t2_ack_set", 64'(ack0), 64'd1);
        req = 1'b0;
        wait_ack(1'b0, 1'b0);
        repeat (4) tick();

        // Back-to-back transfers 1, 2, 3
        got0.delete();
        rdy = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            data = DW'(k); req = 1'b1;
            wait_ack(1'b1, 1'b0);
            req = 1'b0;
            wait_ack(1'b0, 1'b0);
        end
        repeat (5) tick();
        chk("t3_count", 64'(got0.size()), 64'd3);
        for (int i = 0; i < got0.size() && i < 3; i++) chk("t3_order", 64'(got0[i]), 64'(i + 1));

        // Request withdrawn while holding: sticky error, transfer still completes
        do_reset();
        rdy = 1'b0; data = 32'h5A5AA5A5; req = 1'b1;
        wait_vld();
        req = 1'b0;
        for (int n = 0; n < 10 && err0 !== 1'b1; n++) tick();
        chk("t4_err_set", 64'(err0), 64'd1);
        repeat (3) begin
            tick();
            chk("t4_err_hold", 64'(err0), 64'd1);
            chk("t4_vld_hold", 64'(vld0), 64'd1);
        end
        rdy = 1'b1;
        tick();
        chk("t4_vld_clr", 64'(vld0), 64'd0);
        chk("t4_ack_set", 64'(ack0), 64'd1);
        tick();
        chk("t4_ack_1cyc", 64'(ack0), 64'd0);
        repeat (3) tick();
        chk("t4_err_sticky", 64'(err0), 64'd1);

        // Reset mid-transfer drops valid; held request recaptured after release
        do_reset();
        rdy = 1'b0; data = 32'h12345678; req = 1'b1;
        wait_vld();
        rst_n = 1'b0;
        tick();
        chk("t5_vld0", 64'(vld0), 64'd0);
        chk("t5_ack0", 64'(ack0), 64'd0);
        chk("t5_err0", 64'(err0), 64'd0);
        chk("t5_dout0", 64'(dout0), 64'd0);
        chk("t5_vld1", 64'(vld1), 64'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            v0[i] = vld0; v1[i] = vld1;
        end
        chk("t5_vld_early", 64'(v0[1]), 64'd0);
        chk("t5_vld_dp2", 64'(v0[2]), 64'd1);
        chk("t5_vld_dp3_early", 64'(v1[2]), 64'd0);
        chk("t5_vld_dp3", 64'(v1[3]), 64'd1);
        req = 1'b0; rdy = 1'b1;
        repeat (8) tick();

        // Randomized well-behaved sender with random consumer backpressure
        do_reset();
        got0.delete();
        sent.delete();
        for (int t = 0; t < 30; t++) begin
            data = $urandom;
            sent.push_back(data);
            req = 1'b1;
            wait_ack(1'b1, 1'b1);
            repeat ($urandom_range(0, 3)) rtick();
            req = 1'b0;
            wait_ack(1'b0, 1'b1);
            repeat ($urandom_range(0, 2)) rtick();
        end
        rdy = 1'b1;
        repeat (8) tick();
        chk("rnd_count", 64'(got0.size()), 64'(sent.size()));
        for (int i = 0; i < got0.size() && i < sent.size(); i++)
            chk("rnd_data", 64'(got0[i]), 64'(sent[i]));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
